g_aetcam_ctrl: RTL and testbench

Command controller for the flip-flop ternary CAM (`g_aetcam`). It owns the CAM write port and search key, and manages entry allocation with a valid bitmap and lowest-free-index allocation. Insert and delete requests share the CAM write port through a round-robin arbiter; lookups are pipelined alongside. The CAM is instantiated one bit wider than the user key: the MSB is an entry-valid bit that every lookup presents as 1, so deleted or never-written entries cannot match.

---
 rtl/g_aetcam_ctrl.sv | 130 +++++++++++++
 tb/tb_g_aetcam_ctrl.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/g_aetcam_ctrl.sv
// g_aetcam_ctrl: command controller for the ternary CAM with entry allocation, update arbitration and pipelined lookup
module g_aetcam_ctrl #(
  parameter int DEPTH = 64,
  parameter int WIDTH = 36,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ins_valid,
  output logic             ins_ready,
  input  logic [WIDTH-1:0] ins_patt,
  input  logic [WIDTH-1:0] ins_mask,
  input  logic             del_valid,
  output logic             del_ready,
  input  logic [AW-1:0]    del_addr,
  output logic             upd_done,
  output logic             upd_op,
  output logic [AW-1:0]    upd_addr,
  output logic             upd_fail,
  input  logic             lkp_valid,
  output logic             lkp_ready,
  input  logic [WIDTH-1:0] lkp_key,
  output logic             lkp_rsp_valid,
  output logic             lkp_hit,
  output logic [AW-1:0]    lkp_addr,
  output logic             cam_wEn,
  output logic [AW-1:0]    cam_wAddr,
  output logic [WIDTH:0]   cam_wPatt,
  output logic [WIDTH:0]   cam_wMask,
  output logic [WIDTH:0]   cam_mPatt,
  input  logic             cam_match,
  input  logic [AW-1:0]    cam_mAddr,
  output logic [AW:0]      count,
  output logic             full,
  output logic             empty
);
  typedef enum logic {INIT, READY} state_t;
  state_t state;
  logic [AW-1:0] icnt;
  logic [DEPTH-1:0] bitmap;
  logic last_del;
  logic lkp_pend;
  logic rdy, both, ins_gnt, del_gnt, lkp_gnt;
  logic [AW-1:0] free_idx;
  always_comb begin
    free_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--)
      if (!bitmap[i]) free_idx = AW'(i);
  end
  assign rdy = state == READY;
  assign both = ins_valid && del_valid;
  assign ins_ready = rdy && (!both || last_del);
  assign del_ready = rdy && (!both || !last_del);
  assign lkp_ready = rdy;
  assign ins_gnt = ins_valid && ins_ready;
  assign del_gnt = del_valid && del_ready;
  assign lkp_gnt = lkp_valid && lkp_ready;
  assign full = count == (AW+1)'(DEPTH);
  assign empty = count == '0;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= INIT;
      icnt <= '0;
      bitmap <= '0;
      last_del <= 1'b1;
      lkp_pend <= 1'b0;
      count <= '0;
      upd_done <= 1'b0;
      upd_op <= 1'b0;
      upd_addr <= '0;
      upd_fail <= 1'b0;
      lkp_rsp_valid <= 1'b0;
      lkp_hit <= 1'b0;
      lkp_addr <= '0;
      cam_wEn <= 1'b0;
      cam_wAddr <= '0;
      cam_wPatt <= '0;
      cam_wMask <= '0;
      cam_mPatt <= '0;
    end else begin
      cam_wEn <= 1'b0;
      upd_done <= 1'b0;
      lkp_pend <= lkp_gnt;
      lkp_rsp_valid <= lkp_pend;
      if (lkp_pend) begin
        lkp_hit <= cam_match;
        lkp_addr <= cam_match ? cam_mAddr : '0;
      end
      if (lkp_gnt) cam_mPatt <= {1'b1, lkp_key};
      if (state == INIT) begin
        cam_wEn <= 1'b1;
        cam_wAddr <= icnt;
        cam_wPatt <= '0;
        cam_wMask <= '0;
        icnt <= icnt + 1'b1;
        if (icnt == AW'(DEPTH - 1)) state <= READY;
      end
      if (ins_gnt) begin
        last_del <= 1'b0;
        upd_done <= 1'b1;
        upd_op <= 1'b0;
        upd_fail <= full;
        upd_addr <= full ? '0 : free_idx;
        if (!full) begin
          bitmap[free_idx] <= 1'b1;
          count <= count + 1'b1;
          cam_wEn <= 1'b1;
          cam_wAddr <= free_idx;
          cam_wPatt <= {1'b1, ins_patt};
          cam_wMask <= {1'b0, ins_mask};
        end
      end
      if (del_gnt) begin
        last_del <= 1'b1;
        upd_done <= 1'b1;
        upd_op <= 1'b1;
        upd_fail <= !bitmap[del_addr];
        upd_addr <= del_addr;
        if (bitmap[del_addr]) begin
          bitmap[del_addr] <= 1'b0;
          count <= count - 1'b1;
          cam_wEn <= 1'b1;
          cam_wAddr <= del_addr;
          cam_wPatt <= '0;
          cam_wMask <= '0;
        end
      end
    end
  end
endmodule

// File: tb/tb_g_aetcam_ctrl.sv
// tb_g_aetcam_ctrl: directed checks of the CAM controller against a behavioural ternary CAM
module tb_g_aetcam_ctrl;
  localparam int DEPTH = 8;
  localparam int WIDTH = 8;
  localparam int AW = 3;
  logic clk = 0, rst = 1;
  logic ins_valid = 0, del_valid = 0, lkp_valid = 0;
  logic [WIDTH-1:0] ins_patt = 0, ins_mask = 0, lkp_key = 0;
  logic [AW-1:0] del_addr = 0;
  logic ins_ready, del_ready, lkp_ready, upd_done, upd_op, upd_fail;
  logic lkp_rsp_valid, lkp_hit, cam_wEn, cam_match, full, empty;
  logic [AW-1:0] upd_addr, lkp_addr, cam_wAddr, cam_mAddr;
  logic [WIDTH:0] cam_wPatt, cam_wMask, cam_mPatt;
  logic [AW:0] count;
  logic [WIDTH:0] cp [DEPTH];
  logic [WIDTH:0] cm [DEPTH];
  int checks = 0, errors = 0;
  g_aetcam_ctrl #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst),
    .ins_valid(ins_valid), .ins_ready(ins_ready), .ins_patt(ins_patt), .ins_mask(ins_mask),
    .del_valid(del_valid), .del_ready(del_ready), .del_addr(del_addr),
    .upd_done(upd_done), .upd_op(upd_op), .upd_addr(upd_addr), .upd_fail(upd_fail),
    .lkp_valid(lkp_valid), .lkp_ready(lkp_ready), .lkp_key(lkp_key),
    .lkp_rsp_valid(lkp_rsp_valid), .lkp_hit(lkp_hit), .lkp_addr(lkp_addr),
    .cam_wEn(cam_wEn), .cam_wAddr(cam_wAddr), .cam_wPatt(cam_wPatt), .cam_wMask(cam_wMask),
    .cam_mPatt(cam_mPatt), .cam_match(cam_match), .cam_mAddr(cam_mAddr),
    .count(count), .full(full), .empty(empty)
  );
  always #5 clk = ~clk;
  // Behavioural CAM: lowest matching index wins, mask bit 1 is don't-care
  always @(posedge clk)
    if (cam_wEn) begin
      cp[cam_wAddr] <= cam_wPatt;
      cm[cam_wAddr] <= cam_wMask;
    end
  always_comb begin
    cam_match = 1'b0;
    cam_mAddr = '0;
    for (int i = DEPTH - 1; i >= 0; i--)
      if (((cp[i] ^ cam_mPatt) & ~cm[i]) == '0) begin
        cam_match = 1'b1;
        cam_mAddr = AW'(i);
      end
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic upd(input bit is_del, input logic [7:0] patt, input logic [7:0] mask,
                     input int addr, input int exp_addr, input bit exp_fail, input string tag);
    ins_valid = !is_del;
    del_valid = is_del;
    ins_patt = patt;
    ins_mask = mask;
    del_addr = AW'(addr);
    #1 chk({tag, "_rdy"}, is_del ? del_ready : ins_ready, 1);
    tick();
    ins_valid = 0;
    del_valid = 0;
    chk({tag, "_done"}, upd_done, 1);
    chk({tag, "_op"}, upd_op, is_del);
    chk({tag, "_addr"}, upd_addr, exp_addr);
    chk({tag, "_fail"}, upd_fail, exp_fail);
    chk({tag, "_wen"}, cam_wEn, !exp_fail);
  endtask
  task automatic lkp(input logic [7:0] key, input bit hit, input int addr, input string tag);
    lkp_valid = 1;
    lkp_key = key;
    #1 chk({tag, "_rdy"}, lkp_ready, 1);
    tick();
    lkp_valid = 0;
    chk({tag, "_early"}, lkp_rsp_valid, 0);
    tick();
    chk({tag, "_rsp"}, lkp_rsp_valid, 1);
    chk({tag, "_hit"}, lkp_hit, hit);
    chk({tag, "_addr"}, lkp_addr, addr);
  endtask
  initial begin
    logic [7:0] abc [3];
    int fill [5];
    abc = '{8'h11, 8'h22, 8'h33};
    fill = '{0, 4, 5, 6, 7};
    tick();
    tick();
    chk("rst_wen", cam_wEn, 0);
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_ins_rdy", ins_ready, 0);
    chk("rst_done", upd_done, 0);
    chk("rst_rsp", lkp_rsp_valid, 0);
    rst = 0;
    chk("c0_rdy", lkp_ready, 0);
    for (int c = 1; c <= 8; c++) begin
      tick();
      chk("init_wen", cam_wEn, 1);
      chk("init_waddr", cam_wAddr, c - 1);
      chk("init_rdy", lkp_ready, c == 8);
      chk("init_del_rdy", del_ready, c == 8);
    end
    tick();
    chk("idle_wen", cam_wEn, 0);
    chk("idle_count", count, 0);
    chk("idle_empty", empty, 1);
    ins_valid = 1;
    ins_mask = 0;
    for (int i = 0; i < 3; i++) begin
      ins_patt = abc[i];
      tick();
      chk("abc_done", upd_done, 1);
      chk("abc_addr", upd_addr, i);
      chk("abc_waddr", cam_wAddr, i);
      chk("abc_wpatt", cam_wPatt, {1'b1, abc[i]});
      chk("abc_wmask", cam_wMask, 0);
    end
    ins_valid = 0;
    chk("abc_count", count, 3);
    chk("abc_empty", empty, 0);
    lkp(8'h11, 1, 0, "lkpA");
    lkp(8'h99, 0, 0, "lkp_miss");
    upd(0, 8'h05, 8'h03, 0, 3, 0, "ins5");
    chk("ins5_wmask", cam_wMask, 9'h003);
    lkp(8'h06, 1, 3, "lkp6");
    upd(1, 0, 0, 1, 1, 0, "del1");
    chk("del1_wpatt", cam_wPatt, 0);
    lkp(8'h22, 0, 0, "lkpB");
    upd(0, 8'h44, 8'h00, 0, 1, 0, "reuse1");
    chk("reuse1_count", count, 4);
    upd(1, 0, 0, 5, 5, 1, "del5");
    chk("del5_count", count, 4);
    del_valid = 1;
    del_addr = 2;
    lkp_valid = 1;
    lkp_key = 8'h33;
    tick();
    del_valid = 0;
    lkp_valid = 0;
    chk("same_del_fail", upd_fail, 0);
    tick();
    chk("same_rsp", lkp_rsp_valid, 1);
    chk("same_hit", lkp_hit, 1);
    chk("same_addr", lkp_addr, 2);
    upd(0, 8'h33, 8'h00, 0, 2, 0, "reinsC");
    del_valid = 1;
    del_addr = 2;
    tick();
    del_valid = 0;
    chk("next_del_fail", upd_fail, 0);
    chk("next_del_addr", upd_addr, 2);
    lkp_valid = 1;
    lkp_key = 8'h33;
    tick();
    lkp_valid = 0;
    tick();
    chk("next_rsp", lkp_rsp_valid, 1);
    chk("next_hit", lkp_hit, 0);
    chk("next_addr", lkp_addr, 0);
    chk("next_count", count, 3);
    ins_valid = 1;
    del_valid = 1;
    del_addr = 0;
    ins_patt = 8'h77;
    for (int i = 0; i < 4; i++) begin
      #1 chk("arb_ins_rdy", ins_ready, i % 2 == 0);
      chk("arb_del_rdy", del_ready, i % 2 == 1);
      tick();
      chk("arb_op", upd_op, i % 2);
      chk("arb_addr", upd_addr, i == 0 ? 2 : 0);
      chk("arb_fail", upd_fail, 0);
    end
    ins_valid = 0;
    del_valid = 0;
    chk("arb_count", count, 3);
    for (int i = 0; i < 5; i++) upd(0, 8'h80 + 8'(i), 8'h00, 0, fill[i], 0, "fill");
    chk("fill_full", full, 1);
    chk("fill_count", count, 8);
    upd(0, 8'hAA, 8'h00, 0, 0, 1, "ovf");
    chk("ovf_full", full, 1);
    chk("ovf_count", count, 8);
    upd(1, 0, 0, 7, 7, 0, "del7");
    chk("del7_count", count, 7);
    ins_valid = 1;
    ins_patt = 8'h12;
    lkp_valid = 1;
    lkp_key = 8'h11;
    tick();
    chk("inflight_done", upd_done, 1);
    rst = 1;
    lkp_valid = 0;
    tick();
    chk("mrst_done", upd_done, 0);
    chk("mrst_rsp", lkp_rsp_valid, 0);
    chk("mrst_wen", cam_wEn, 0);
    chk("mrst_count", count, 0);
    chk("mrst_empty", empty, 1);
    chk("mrst_rdy", ins_ready, 0);
    ins_valid = 0;
    rst = 0;
    tick();
    chk("reinit_wen", cam_wEn, 1);
    chk("reinit_waddr", cam_wAddr, 0);
    chk("reinit_rsp", lkp_rsp_valid, 0);
    chk("reinit_done", upd_done, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
